serial_adder: RTL and testbench

Bit-serial N-bit adder built around one `full_adder` instance plus a registered carry. Sits directly downstream of `full_adder`: each clock it feeds the adder one operand bit pair and the stored carry, then registers the adder's `sum` and `cout`. Operands are loaded in parallel on a start pulse. The result is presented in parallel with a one-cycle done strobe. Used where area matters more than throughput.

---
 rtl/serial_adder_if.sv | 19 +
 rtl/serial_adder.sv | 79 +++++++
 tb/tb_serial_adder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for serial_adder; ovf exists only with SERIAL_ADDER_OVF_EN
interface serial_adder_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around one full_adder and a registered carry
// SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow flag
module full_adder (
   input  logic in1,
   input  logic in2,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum = in1 ^ in2 ^ cin;
   assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_adder #(parameter int WIDTH = 8) (
   input logic         clk,
   input logic         rst,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic [WIDTH:0]   res_ext;
   logic [CW-1:0]    cnt;
   logic             c_q, fa_s, fa_c, last, load;

   full_adder u_fa (.in1(a_sh[0]), .in2(b_sh[0]), .cin(c_q), .sum(fa_s), .cout(fa_c));

   // new sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts
   assign res_ext = {fa_s, res};
   assign last = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign load = bus.start && (state != RUN);

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = load ? RUN : (state == RUN && !last) ? RUN : last ? DONE : IDLE;
   end

   always_comb begin
      bus.busy = state == RUN;
      bus.done = state == DONE;
   end

   always_ff @(posedge clk)
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         res <= '0;
         c_q <= 1'b0;
         cnt <= '0;
         bus.sum <= '0;
         bus.cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         bus.ovf <= 1'b0;
`endif
      end else if (load) begin
         a_sh <= bus.a;
         b_sh <= bus.b;
         c_q <= bus.cin;
         cnt <= '0;
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         res <= res_ext[WIDTH:1];
         c_q <= fa_c;
         cnt <= cnt + CW'(1);
         if (last) begin
            bus.sum <= res_ext[WIDTH:1];
            bus.cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // c_q holds the carry into the MSB during the last bit
            bus.ovf <= c_q ^ fa_c;
`endif
         end
      end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against plain-arithmetic expectations
module tb_serial_adder;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;

   serial_adder_if #(.WIDTH(W)) bus ();
   serial_adder_if #(.WIDTH(1)) bus1 ();
   serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + (W+1)'(c);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
      return (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
   endfunction

   task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] e;
      e = ref_sum(a, b, c);
      chk("sum", 64'(bus.sum), 64'(e[W-1:0]));
      chk("cout", 64'(bus.cout), 64'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", 64'(bus.ovf), 64'(ref_ovf(a, b, c)));
`endif
   endtask

   // inj >= 1 pulses a garbage start after that RUN edge
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int inj);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.cin = c;
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("busy_e0", 64'(bus.busy), 64'd1);
      chk("done_e0", 64'(bus.done), 64'd0);
      for (int k = 1; k < W; k++) begin
         @(posedge clk);
         #1;
         bus.start = (k == inj);
         if (k == inj) begin
            bus.a = '1;
            bus.b = '1;
         end
         chk("busy_run", 64'(bus.busy), 64'd1);
         chk("done_run", 64'(bus.done), 64'd0);
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("busy_done", 64'(bus.busy), 64'd0);
      chk("done_strobe", 64'(bus.done), 64'd1);
      check_result(a, b, c);
      @(posedge clk);
      #1 chk("done_drop", 64'(bus.done), 64'd0);
      check_result(a, b, c);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic rc;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      bus1.start = 1'b0;
      bus1.a = '0;
      bus1.b = '0;
      bus1.cin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_sum", 64'(bus.sum), 64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
      do_op(8'h0F, 8'h01, 1'b0, 0);
      do_op(8'hFF, 8'h01, 1'b0, 0);
      do_op(8'h7F, 8'h01, 1'b0, 0);
      do_op(8'h12, 8'h34, 1'b0, 3);
      chk("ignored_sum", 64'(bus.sum), 64'h46);
      // reset lands on the 4th RUN edge
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'h5A;
      bus.b = 8'h33;
      bus.cin = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_done", 64'(bus.done), 64'd0);
      chk("midrst_sum", 64'(bus.sum), 64'd0);
      chk("midrst_cout", 64'(bus.cout), 64'd0);
      repeat (10) begin
         @(posedge clk);
         #1 chk("midrst_nodone", 64'(bus.done), 64'd0);
      end
      do_op(8'h01, 8'h01, 1'b0, 0);
      // start held high: one result every W+1 cycles
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'h01;
      bus.b = 8'h02;
      bus.cin = 1'b1;
      for (int i = 0; i < 3 * (W + 1); i++) begin
         @(posedge clk);
         #1;
         chk("held_done", 64'(bus.done), 64'((i % (W + 1)) == W));
         chk("held_busy", 64'(bus.busy), 64'((i % (W + 1)) != W));
         if ((i % (W + 1)) == W) chk("held_sum", 64'(bus.sum), 64'h04);
      end
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      for (int n = 0; n < 16; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         do_op(ra, rb, rc, 0);
      end
      // single-bit instance
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.a = 1'b1;
      bus1.b = 1'b1;
      bus1.cin = 1'b1;
      @(posedge clk);
      #1 bus1.start = 1'b0;
      chk("w1_busy", 64'(bus1.busy), 64'd1);
      @(posedge clk);
      #1;
      chk("w1_done", 64'(bus1.done), 64'd1);
      chk("w1_sum", 64'(bus1.sum), 64'd1);
      chk("w1_cout", 64'(bus1.cout), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
